ks_addsub_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone adder/subtractor with full N/Z/C/V flags, carry-in modes and a valid/ready handshake.
- Generalises the 8-bit combinational add/sub to any power-of-two width, with registered prefix levels.
- Sits in the RISC-V CPU execute stage as the ALU add/sub/compare datapath. Also usable standalone for multi-word arithmetic, via carry chaining.

---
 rtl/ks_addsub_pipe.sv | 131 +++++++++++++
 tb/tb_ks_addsub_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with N/Z/C/V flags, carry-in modes
// and a valid/ready handshake. A single advance enable stalls the whole pipe.
module ks_addsub_pipe #(
  parameter int WIDTH          = 32,
  parameter int LVLS_PER_STAGE = 2,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int NSTG = (LOG + LVLS_PER_STAGE - 1) / LVLS_PER_STAGE;

  // Applies prefix levels lo..hi; level k combines distance 2^(k-1).
  function automatic logic [2*WIDTH-1:0] ks_levels(input logic [WIDTH-1:0] g,
                                                   input logic [WIDTH-1:0] p,
                                                   input int lo, input int hi);
    logic [WIDTH-1:0] gg, pp, gn, pn;
    gg = g;
    pp = p;
    for (int k = 1; k <= LOG; k++) begin
      if (k >= lo && k <= hi) begin
        gn = gg;
        pn = pp;
        for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
          gn[i] = gg[i] | (pp[i] & gg[i - (1 << (k - 1))]);
          pn[i] = pp[i] & pp[i - (1 << (k - 1))];
        end
        gg = gn;
        pp = pn;
      end
    end
    return {gg, pp};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff, g_in, p_in, g_fold;
  logic             c0_in;

  logic [WIDTH-1:0] st_g   [NSTG];
  logic [WIDTH-1:0] st_p   [NSTG];
  logic [WIDTH-1:0] st_po  [NSTG];
  logic             st_c0  [NSTG];
  logic             st_v   [NSTG];
  logic [TAG_W-1:0] st_tag [NSTG];

  logic [WIDTH-1:0] nxt_g [1:NSTG];
  logic [WIDTH-1:0] nxt_p [1:NSTG];
  logic [WIDTH-1:0] fin_g, fin_sum;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Carry-in is folded into bit 0 so G[i:0] is directly the carry into bit i+1.
  always_comb begin
    b_eff  = in_b ^ {WIDTH{in_op[0]}};
    c0_in  = in_op[1] ? in_cin : in_op[0];
    g_in   = in_a & b_eff;
    p_in   = in_a ^ b_eff;
    g_fold = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & c0_in)};
  end

  always_comb begin
    for (int s = 1; s <= NSTG; s++) begin
      {nxt_g[s], nxt_p[s]} = ks_levels(st_g[s-1], st_p[s-1],
                                       (s - 1) * LVLS_PER_STAGE + 1,
                                       s * LVLS_PER_STAGE);
    end
    fin_g   = nxt_g[NSTG];
    fin_sum = st_po[NSTG-1] ^ {fin_g[WIDTH-2:0], st_c0[NSTG-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTG; s++) begin
        st_g[s]   <= '0;
        st_p[s]   <= '0;
        st_po[s]  <= '0;
        st_c0[s]  <= 1'b0;
        st_v[s]   <= 1'b0;
        st_tag[s] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_n     <= 1'b0;
      out_z     <= 1'b0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      st_g[0]   <= g_fold;
      st_p[0]   <= p_in;
      st_po[0]  <= p_in;
      st_c0[0]  <= c0_in;
      st_v[0]   <= in_valid;
      st_tag[0] <= in_tag;
      for (int s = 1; s < NSTG; s++) begin
        st_g[s]   <= nxt_g[s];
        st_p[s]   <= nxt_p[s];
        st_po[s]  <= st_po[s-1];
        st_c0[s]  <= st_c0[s-1];
        st_v[s]   <= st_v[s-1];
        st_tag[s] <= st_tag[s-1];
      end
      out_valid <= st_v[NSTG-1];
      out_sum   <= fin_sum;
      out_n     <= fin_sum[WIDTH-1];
      out_z     <= ~|fin_sum;
      out_c     <= fin_g[WIDTH-1];
      out_v     <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
      out_tag   <= st_tag[NSTG-1];
    end
  end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Bench for ks_addsub_pipe: three instances (32/2, 8/1, 64/3) checked against
// a plain-arithmetic reference model through a per-instance scoreboard.
module tb_ks_addsub_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        n, z, c, v;
    logic [4:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [63:0] a_s [3];
  logic [63:0] b_s [3];
  logic [1:0]  op_s [3];
  logic        cin_s [3];
  logic        v_s [3];
  logic        or_s [3];
  logic [4:0]  tag_s [3];

  logic        rdy [3];
  logic        ov [3];
  logic        on [3];
  logic        oz [3];
  logic        oc [3];
  logic        ovf [3];
  logic [4:0]  otag [3];
  logic [63:0] osum [3];
  logic [31:0] sum0;
  logic [7:0]  sum1;
  logic [63:0] sum2;
  assign osum[0] = {32'd0, sum0};
  assign osum[1] = {56'd0, sum1};
  assign osum[2] = sum2;

  ks_addsub_pipe #(.WIDTH(32), .LVLS_PER_STAGE(2), .TAG_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s[0]), .in_ready(rdy[0]),
    .in_a(a_s[0][31:0]), .in_b(b_s[0][31:0]), .in_op(op_s[0]), .in_cin(cin_s[0]),
    .in_tag(tag_s[0]), .out_valid(ov[0]), .out_ready(or_s[0]), .out_sum(sum0),
    .out_n(on[0]), .out_z(oz[0]), .out_c(oc[0]), .out_v(ovf[0]), .out_tag(otag[0]));

  ks_addsub_pipe #(.WIDTH(8), .LVLS_PER_STAGE(1), .TAG_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s[1]), .in_ready(rdy[1]),
    .in_a(a_s[1][7:0]), .in_b(b_s[1][7:0]), .in_op(op_s[1]), .in_cin(cin_s[1]),
    .in_tag(tag_s[1]), .out_valid(ov[1]), .out_ready(or_s[1]), .out_sum(sum1),
    .out_n(on[1]), .out_z(oz[1]), .out_c(oc[1]), .out_v(ovf[1]), .out_tag(otag[1]));

  ks_addsub_pipe #(.WIDTH(64), .LVLS_PER_STAGE(3), .TAG_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s[2]), .in_ready(rdy[2]),
    .in_a(a_s[2]), .in_b(b_s[2]), .in_op(op_s[2]), .in_cin(cin_s[2]),
    .in_tag(tag_s[2]), .out_valid(ov[2]), .out_ready(or_s[2]), .out_sum(sum2),
    .out_n(on[2]), .out_z(oz[2]), .out_c(oc[2]), .out_v(ovf[2]), .out_tag(otag[2]));

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_on = 1'b1;
  exp_t sb [3][256];
  int   wr [3];
  int   rd [3];

  function automatic int wd(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 64;
  endfunction

  function automatic int lat(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic logic [63:0] mask(input int d);
    return (wd(d) == 64) ? '1 : ((64'd1 << wd(d)) - 64'd1);
  endfunction

  // Reference: true integer sum of a + (b or ~b) + carry-in, reduced mod 2^w.
  function automatic exp_t ref_calc(input int w, input logic [63:0] a,
                                    input logic [63:0] b, input logic [1:0] op,
                                    input logic cin, input logic [4:0] tag);
    exp_t        e;
    logic [64:0] m, bb, full, s;
    logic        c0;
    m    = (65'd1 << w) - 65'd1;
    bb   = op[0] ? ({1'b0, ~b} & m) : ({1'b0, b} & m);
    c0   = op[1] ? cin : op[0];
    full = ({1'b0, a} & m) + bb + {64'd0, c0};
    s    = full & m;
    e.sum = s[63:0];
    e.n   = s[w-1];
    e.z   = (s == 65'd0);
    e.c   = full[w];
    e.v   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    e.tag = tag;
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // One clock: score drains, record accepts, advance to 1 time unit past the edge.
  task automatic step();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && or_s[d]) begin
        if (rd[d] == wr[d]) begin
          chk($sformatf("d%0d_unexpected_out_valid", d), 64'(ov[d]), 64'd0);
        end else begin
          e = sb[d][rd[d] % 256];
          rd[d]++;
          chk($sformatf("d%0d_sum", d), osum[d], e.sum);
          chk($sformatf("d%0d_nzcv", d), 64'({on[d], oz[d], oc[d], ovf[d]}),
              64'({e.n, e.z, e.c, e.v}));
          chk($sformatf("d%0d_tag", d), 64'(otag[d]), 64'(e.tag));
          if (e.lat) chk($sformatf("d%0d_latency", d), 64'(cyc - e.cyc), 64'(lat(d)));
        end
      end
      if (v_s[d] && rdy[d]) begin
        e = ref_calc(wd(d), a_s[d], b_s[d], op_s[d], cin_s[d], tag_s[d]);
        e.cyc = cyc;
        e.lat = lat_on;
        sb[d][wr[d] % 256] = e;
        wr[d]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic directed(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic cin, input logic [31:0] es,
                          input logic [3:0] enzcv, output logic c_out);
    int         n;
    logic [4:0] t;
    t = 5'($urandom);
    a_s[0] = a; b_s[0] = b; op_s[0] = op; cin_s[0] = cin; tag_s[0] = t;
    v_s[0] = 1'b1; or_s[0] = 1'b1;
    step();
    v_s[0] = 1'b0;
    n = 1;
    while (!ov[0] && n < 10) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_sum"}, osum[0], {32'd0, es});
    chk({nm, "_nzcv"}, 64'({on[0], oz[0], oc[0], ovf[0]}), 64'(enzcv));
    chk({nm, "_tag"}, 64'(otag[0]), 64'(t));
    c_out = oc[0];
    step();
  endtask

  task automatic stream(input int d, input int n, input int stall_at);
    int          sent, k, k2;
    bit          pending;
    logic [63:0] s_sum;
    logic [4:0]  s_tag;
    logic [3:0]  s_fl;
    sent = 0; k = 0; pending = 1'b0;
    s_sum = '0; s_tag = '0; s_fl = '0;
    while (sent < n && k < 2000) begin
      if (!pending) begin
        a_s[d]   = {$urandom, $urandom} & mask(d);
        b_s[d]   = {$urandom, $urandom} & mask(d);
        op_s[d]  = 2'($urandom_range(0, 3));
        cin_s[d] = 1'($urandom);
        tag_s[d] = 5'($urandom);
        pending  = 1'b1;
      end
      v_s[d]  = 1'b1;
      or_s[d] = !(stall_at >= 0 && k >= stall_at && k < stall_at + 3);
      #1;
      if (!or_s[d]) begin
        chk($sformatf("d%0d_stall_in_ready", d), 64'(rdy[d]), 64'd0);
        chk($sformatf("d%0d_stall_out_valid", d), 64'(ov[d]), 64'd1);
        if (k == stall_at) begin
          s_sum = osum[d]; s_tag = otag[d]; s_fl = {on[d], oz[d], oc[d], ovf[d]};
        end else begin
          chk($sformatf("d%0d_stall_sum_hold", d), osum[d], s_sum);
          chk($sformatf("d%0d_stall_flag_hold", d), 64'({on[d], oz[d], oc[d], ovf[d]}), 64'(s_fl));
          chk($sformatf("d%0d_stall_tag_hold", d), 64'(otag[d]), 64'(s_tag));
        end
      end
      if (rdy[d]) begin
        sent++;
        pending = 1'b0;
      end
      step();
      k++;
    end
    if (stall_at < 0) chk($sformatf("d%0d_stream_cycles", d), 64'(k), 64'(n));
    v_s[d] = 1'b0;
    or_s[d] = 1'b1;
    k2 = 0;
    while (rd[d] != wr[d] && k2 < 50) begin
      step();
      k2++;
    end
    chk($sformatf("d%0d_all_drained", d), 64'(wr[d] - rd[d]), 64'd0);
  endtask

  initial begin
    logic c_lo, c_dummy;
    for (int d = 0; d < 3; d++) begin
      a_s[d] = '0; b_s[d] = '0; op_s[d] = '0; cin_s[d] = 1'b0; tag_s[d] = '0;
      v_s[d] = 1'b0; or_s[d] = 1'b1; wr[d] = 0; rd[d] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_reset_out_valid", d), 64'(ov[d]), 64'd0);
      chk($sformatf("d%0d_reset_sum", d), osum[d], 64'd0);
      chk($sformatf("d%0d_reset_flags_tag", d),
          64'({on[d], oz[d], oc[d], ovf[d], otag[d]}), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_in_ready_after_reset", d), 64'(rdy[d]), 64'd1);

    directed("add_wrap", 64'hFFFF_FFFF, 64'd1, 2'b00, 1'b0, 32'h0, 4'b0110, c_dummy);
    directed("sub_ovf", 64'h8000_0000, 64'd1, 2'b01, 1'b0, 32'h7FFF_FFFF, 4'b0011, c_dummy);
    directed("sub_neg", 64'd5, 64'd7, 2'b01, 1'b0, 32'hFFFF_FFFE, 4'b1000, c_dummy);
    directed("chain_lo", 64'hFFFF_FFFF, 64'd1, 2'b00, 1'b0, 32'h0, 4'b0110, c_lo);
    directed("chain_hi", 64'd0, 64'd0, 2'b10, c_lo, 32'h1, 4'b0000, c_dummy);
    directed("sbb_borrow", 64'd0, 64'd0, 2'b11, 1'b0, 32'hFFFF_FFFF, 4'b1000, c_dummy);

    stream(0, 100, -1);
    lat_on = 1'b0;
    stream(0, 40, 10);
    lat_on = 1'b1;

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a_s[0] = 64'($urandom); b_s[0] = 64'($urandom); op_s[0] = 2'($urandom_range(0, 3));
      tag_s[0] = 5'($urandom); v_s[0] = 1'b1;
      step();
    end
    v_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_mid_sum", osum[0], 64'd0);
    chk("rst_mid_flags_tag", 64'({on[0], oz[0], oc[0], ovf[0], otag[0]}), 64'd0);
    rd[0] = wr[0];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(rdy[0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_stale", 64'(ov[0]), 64'd0);
      step();
    end

    stream(1, 100, -1);
    stream(2, 100, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
